fifo_rr_drain: RTL and testbench
================================

// Module: fifo_rr_drain
// PURPOSE
//  Round-robin scheduler that drains NUM_SRC show-ahead fifo instances into one
//  downstream valid/ready consumer, e.g. several issue queues sharing one write port.
//  Each cycle it picks at most one non-empty source and pulses that fifo's read.
//  The popped word is registered into a one-entry output stage, tagged with its source.
//  A per-owner burst quantum bounds how long one source may hold the port.
// PARAMETERS
//  WIDTH    32  data width of every source fifo and of out_data
//  NUM_SRC  2   number of source fifos (2..8)
//  QUANTUM  4   max consecutive grants to one source while others wait (>=1)
// PORTS
//  clk        in   1              clock; all state updates on posedge
//  reset      in   1              synchronous, active-high reset
//  flush      in   1              drop buffered output word; no pops this cycle
//  src_empty  in   NUM_SRC        per-source fifo empty flag
//  src_data   in   NUM_SRC*WIDTH  per-source fifo outdata; source i at [i*WIDTH +: WIDTH]
//  src_read   out  NUM_SRC        one-hot-or-zero read pulse to source fifos
//  out_valid  out  1              output register holds a word
//  out_data   out  WIDTH          registered word
//  out_src    out  clog2(NUM_SRC) index of the source that supplied out_data
//  out_ready  in   1              consumer accepts when out_valid & out_ready
// BEHAVIOUR
//  Reset: out_valid=0, out_data=0, out_src=0, state=IDLE, burst_cnt=0, rr_ptr=NUM_SRC-1.
//  After reset, source 0 has top priority.
//  - load = ~flush & (~out_valid | out_ready). A pop is allowed only when load=1.
//  - src_read is combinational. It is zero when load=0, when all sources are empty, or during reset.
//  - Popped word appears on out_data with out_valid=1 the next cycle: one cycle latency.
//    Sustained throughput is 1 word/cycle while out_ready=1.
//  - No pop when out_valid & ~out_ready: out_data, out_src and out_valid hold stable.
//  - If out_valid & out_ready and no pop, out_valid falls next cycle.
//  Grant selection (rr_pick, rotating priority starting at rr_ptr+1 mod NUM_SRC):
//  - IDLE: grant = first non-empty source. On pop: owner=grant, burst_cnt=1, rr_ptr=grant.
//    Next state is BURST if QUANTUM>1, otherwise stay IDLE.
//  - BURST: if owner is non-empty and burst_cnt<QUANTUM, grant=owner and burst_cnt++.
//    Otherwise grant comes from rr_pick, and a new owner restarts burst_cnt=1.
//    If nothing is poppable, go to IDLE.
//  - When load=0, state, rr_ptr and burst_cnt hold.
//  - Quantum exception: if only the owner is non-empty, it keeps the grant past QUANTUM.
//    burst_cnt saturates at QUANTUM.
//  - flush: out_valid<=0 next cycle and state<=IDLE. rr_ptr is preserved, src_read=0.
//    flush overrides out_ready.
//  - Reset mid-burst: everything returns to reset values next cycle.
//    Words already popped from fifos are lost (the fifos are reset together).
//  - rr_ptr wraps NUM_SRC-1 -> 0. All index arithmetic is mod NUM_SRC; NUM_SRC need not be a power of 2.
// STRUCTURE
//  Shared package: state encoding (FRD_IDLE, FRD_BURST) and the SRC_IDX_W=clog2(NUM_SRC) helper.
//  One sub-module, rr_pick: combinational rotating-priority encoder.
//  - Inputs: req vector and pointer. Outputs: one-hot grant and its index.
//  - It is reused by other arbiters.
//  Top level: state/owner/burst_cnt/rr_ptr registers, output register, src_data mux.
// TESTING
//  1. NUM_SRC=2, QUANTUM=4, both fifos hold 6 words, out_ready=1.
//     -> out_src sequence 0,0,0,0,1,1,1,1,0,0,1,1.
//     One word per cycle, and the first out_valid comes 1 cycle after the first src_read.
//  2. Only src1 non-empty with 10 words.
//     -> 10 consecutive grants to src1, no quantum break, src_read[0] never asserted.
//  3. Backpressure: out_ready=0 for 3 cycles while out_valid=1.
//     -> src_read=0 and out_data/out_src stable. On out_ready=1 the next word arrives the following cycle.
//  4. flush asserted while out_valid=1 and mid-burst on src0.
//     -> out_valid=0 next cycle and no word lost from the fifos during the flush cycle.
//     -> Arbitration resumes from rr_ptr+1, so src1 goes first.
//  5. reset asserted mid-burst.
//     -> next cycle out_valid=0, out_src=0, src_read=0. After release with both non-empty, src0 is granted first.
//  6. NUM_SRC=3, all sources continuously non-empty, QUANTUM=1.
//     -> out_src 0,1,2,0,1,2; ptr wraps correctly.

Source files
------------

// File: rtl/fifo_rr_drain_pkg.sv
// Shared definitions for the fifo_rr_drain scheduler and its arbiter.
// Contents:
//   frd_state_e : scheduler state encoding (FRD_IDLE, FRD_BURST)
//   src_idx_w   : width of a source index for a given source count
package fifo_rr_drain_pkg;

  typedef enum logic {
    FRD_IDLE  = 1'b0,
    FRD_BURST = 1'b1
  } frd_state_e;

  // Index width for n sources; at least one bit so a single source still has an index.
  function automatic int unsigned src_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_rr_drain_if.sv
// Source-fifo and consumer-side signals of fifo_rr_drain.
// Signals:
//   flush     : drop the buffered output word, no pops this cycle
//   src_empty : per-source fifo empty flag
//   src_data  : per-source show-ahead fifo word, source i at [i*WIDTH +: WIDTH]
//   src_read  : one-hot-or-zero read pulse to the source fifos
//   out_valid : output register holds a word
//   out_data  : registered word
//   out_src   : index of the source that supplied out_data
//   out_ready : consumer accepts when out_valid & out_ready
// Modports: master = the scheduler, slave = fifos and consumer.
interface fifo_rr_drain_if #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NUM_SRC = 2
);
  import fifo_rr_drain_pkg::*;

  localparam int unsigned SRC_IDX_W = src_idx_w(NUM_SRC);

  logic                     flush;
  logic [NUM_SRC-1:0]       src_empty;
  logic [NUM_SRC*WIDTH-1:0] src_data;
  logic [NUM_SRC-1:0]       src_read;
  logic                     out_valid;
  logic [WIDTH-1:0]         out_data;
  logic [SRC_IDX_W-1:0]     out_src;
  logic                     out_ready;

  modport master (
    input  flush, src_empty, src_data, out_ready,
    output src_read, out_valid, out_data, out_src
  );

  modport slave (
    output flush, src_empty, src_data, out_ready,
    input  src_read, out_valid, out_data, out_src
  );

endinterface

// File: rtl/fifo_rr_drain_rr_pick.sv
// Combinational rotating-priority encoder.
// The request just after ptr (mod NUM_SRC) has top priority; ptr itself has lowest.
// Ports:
//   req   : request vector
//   ptr   : last-served index
//   gnt   : one-hot grant (zero when no request)
//   idx   : index of the granted request
//   valid : at least one request present
module fifo_rr_drain_rr_pick import fifo_rr_drain_pkg::*; #(
  parameter  int unsigned NUM_SRC   = 2,
  localparam int unsigned SRC_IDX_W = src_idx_w(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0]   req,
  input  logic [SRC_IDX_W-1:0] ptr,
  output logic [NUM_SRC-1:0]   gnt,
  output logic [SRC_IDX_W-1:0] idx,
  output logic                 valid
);

  logic [SRC_IDX_W-1:0] cand;

  always_comb begin
    cand  = '0;
    idx   = '0;
    valid = |req;
    // Walk from lowest to highest priority so the highest-priority hit is written last.
    for (int off = int'(NUM_SRC); off >= 1; off--) begin
      cand = SRC_IDX_W'((int'(ptr) + off) % int'(NUM_SRC));
      if (req[cand]) begin
        idx = cand;
      end
    end
    gnt = valid ? (NUM_SRC'(1) << idx) : '0;
  end

endmodule

// File: rtl/fifo_rr_drain.sv
// Round-robin drain of NUM_SRC show-ahead fifos into one valid/ready consumer.
// At most one non-empty source is popped per cycle; the word lands in a one-entry
// output register tagged with its source. An owner may keep the port for up to
// QUANTUM consecutive grants while others wait, or indefinitely if it is the only
// non-empty source.
// Ports:
//   clk   : clock, all state on posedge
//   reset : synchronous active-high reset
//   bus   : fifo/consumer signals (master side)
module fifo_rr_drain import fifo_rr_drain_pkg::*; #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned QUANTUM = 4
) (
  input logic            clk,
  input logic            reset,
  fifo_rr_drain_if.master bus
);

  localparam int unsigned SRC_IDX_W = src_idx_w(NUM_SRC);
  localparam int unsigned CNT_W     = $clog2(QUANTUM + 1);
  localparam logic [CNT_W-1:0]     QuantumC = CNT_W'(QUANTUM);
  localparam logic [SRC_IDX_W-1:0] LastSrc  = SRC_IDX_W'(NUM_SRC - 1);

  frd_state_e           state_q, state_d;
  logic [SRC_IDX_W-1:0] owner_q, owner_d;
  logic [SRC_IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]     burst_cnt_q, burst_cnt_d;
  logic                 out_valid_q, out_valid_d;
  logic [WIDTH-1:0]     out_data_q, out_data_d;
  logic [SRC_IDX_W-1:0] out_src_q, out_src_d;

  logic [NUM_SRC-1:0]   req, pick_gnt, grant_oh;
  logic [SRC_IDX_W-1:0] pick_idx, grant_idx;
  logic                 pick_valid, load, owner_keeps, pop;

  assign req = ~bus.src_empty;

  fifo_rr_drain_rr_pick #(
    .NUM_SRC (NUM_SRC)
  ) u_rr_pick (
    .req   (req),
    .ptr   (rr_ptr_q),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;

    load        = ~bus.flush & (~out_valid_q | bus.out_ready);
    owner_keeps = (state_q == FRD_BURST) && req[owner_q] && (burst_cnt_q < QuantumC);
    grant_idx   = owner_keeps ? owner_q : pick_idx;
    grant_oh    = owner_keeps ? (NUM_SRC'(1) << owner_q) : pick_gnt;
    pop         = load & pick_valid & ~reset;

    if (pop) begin
      // A re-grant to the current owner (kept or the only non-empty source) extends
      // its run, saturating at QUANTUM; any other grant starts a fresh run.
      if ((state_q == FRD_BURST) && (grant_idx == owner_q)) begin
        burst_cnt_d = (burst_cnt_q < QuantumC) ? burst_cnt_q + 1'b1 : burst_cnt_q;
      end else begin
        burst_cnt_d = CNT_W'(1);
      end
      owner_d     = grant_idx;
      rr_ptr_d    = grant_idx;
      state_d     = (QUANTUM > 1) ? FRD_BURST : FRD_IDLE;
      out_valid_d = 1'b1;
      out_data_d  = bus.src_data[grant_idx*WIDTH +: WIDTH];
      out_src_d   = grant_idx;
    end else if (load) begin
      out_valid_d = 1'b0;
      state_d     = FRD_IDLE;
    end

    // flush drops the buffered word regardless of out_ready; rr_ptr is kept.
    if (bus.flush) begin
      out_valid_d = 1'b0;
      state_d     = FRD_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= FRD_IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= LastSrc;
      burst_cnt_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
    end
  end

  assign bus.src_read  = pop ? grant_oh : '0;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;

endmodule

// File: tb/tb_fifo_rr_drain.sv
// Randomized self-checking bench for fifo_rr_drain. Two instances are exercised in
// turn: NUM_SRC=2/QUANTUM=4 and NUM_SRC=3/QUANTUM=1. The source fifos and the
// scheduler are modelled behaviourally; the model owns the fifo contents that feed
// the DUT and predicts every read pulse and output-register value.
module tb_fifo_rr_drain;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;

  fifo_rr_drain_if #(.WIDTH(32), .NUM_SRC(2)) bus_a ();
  fifo_rr_drain_if #(.WIDTH(32), .NUM_SRC(3)) bus_b ();

  fifo_rr_drain #(.WIDTH(32), .NUM_SRC(2), .QUANTUM(4)) dut_a (
    .clk   (clk),
    .reset (rst_a),
    .bus   (bus_a)
  );

  fifo_rr_drain #(.WIDTH(32), .NUM_SRC(3), .QUANTUM(1)) dut_b (
    .clk   (clk),
    .reset (rst_b),
    .bus   (bus_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  bit   sel_b;
  int   n_src, quant;
  logic rst_i, flush_i, ready_i;

  // Fifo model: per-source ring with free-running head/tail counts.
  logic [31:0] mem [3][256];
  int          head [3];
  int          tail [3];
  int          serial;

  // Scheduler model.
  bit          m_valid, m_burst;
  logic [31:0] m_data;
  int          m_src, m_owner, m_cnt, m_ptr;

  int          out_log[$];
  logic [7:0]  last_rd;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit nonempty(input int s);
    return head[s] != tail[s];
  endfunction

  task automatic push(input int s, input int n);
    for (int i = 0; i < n; i++) begin
      mem[s][tail[s] % 256] = {8'(s), 24'(serial)};
      serial++;
      tail[s]++;
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_burst = 0; m_data = '0; m_src = 0;
    m_owner = 0; m_cnt = 0; m_ptr = n_src - 1;
    for (int s = 0; s < 3; s++) head[s] = tail[s];
  endtask

  task automatic apply();
    logic [2:0]  e;
    logic [95:0] d;
    for (int s = 0; s < 3; s++) begin
      e[s] = !nonempty(s);
      d[s*32 +: 32] = e[s] ? 32'h0 : mem[s][head[s] % 256];
    end
    rst_a = sel_b ? 1'b1 : rst_i;
    rst_b = sel_b ? rst_i : 1'b1;
    bus_a.src_empty = e[1:0];
    bus_a.src_data  = d[63:0];
    bus_a.flush     = flush_i;
    bus_a.out_ready = ready_i;
    bus_b.src_empty = e;
    bus_b.src_data  = d;
    bus_b.flush     = flush_i;
    bus_b.out_ready = ready_i;
  endtask

  // One clock cycle: drive, predict, compare, then advance model at the edge.
  task automatic step();
    int          g;
    bit          load;
    logic [7:0]  exp_rd, rd;
    logic        v;
    logic [31:0] d;
    int          s;
    apply();
    #1;
    load = !flush_i && (!m_valid || ready_i);
    g = -1;
    if (!rst_i && load) begin
      if (m_burst && nonempty(m_owner) && m_cnt < quant) g = m_owner;
      else
        for (int k = n_src; k >= 1; k--)
          if (nonempty((m_ptr + k) % n_src)) g = (m_ptr + k) % n_src;
    end
    exp_rd = (g >= 0) ? (8'd1 << g) : 8'd0;
    if (sel_b) begin
      rd = 8'(bus_b.src_read); v = bus_b.out_valid; d = bus_b.out_data;
      s = int'(bus_b.out_src);
    end else begin
      rd = 8'(bus_a.src_read); v = bus_a.out_valid; d = bus_a.out_data;
      s = int'(bus_a.out_src);
    end
    last_rd = rd;
    check("src_read", 64'(rd), 64'(exp_rd));
    check("out_valid", 64'(v), 64'(m_valid));
    check("out_data", 64'(d), 64'(m_data));
    check("out_src", 64'(s), 64'(m_src));
    if (v && ready_i && !flush_i && !rst_i) out_log.push_back(s);
    @(posedge clk);
    if (rst_i) begin
      model_reset();
    end else if (g >= 0) begin
      m_data = mem[g][head[g] % 256];
      head[g]++;
      if (m_burst && g == m_owner) m_cnt = (m_cnt < quant) ? m_cnt + 1 : quant;
      else m_cnt = 1;
      m_owner = g; m_ptr = g; m_burst = (quant > 1);
      m_valid = 1; m_src = g;
    end else if (load || flush_i) begin
      m_valid = 0; m_burst = 0;
    end
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst_i = 1; step(); rst_i = 0;
  endtask

  task automatic random_phase(input int n);
    for (int i = 0; i < n; i++) begin
      for (int s = 0; s < n_src; s++)
        if ($urandom_range(0, 2) == 0 && tail[s] - head[s] < 200) push(s, $urandom_range(1, 3));
      ready_i = ($urandom_range(0, 3) != 0);
      flush_i = ($urandom_range(0, 15) == 0);
      rst_i   = ($urandom_range(0, 63) == 0);
      step();
    end
    rst_i = 0; flush_i = 0; ready_i = 1;
  endtask

  int exp1 [12] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 1, 1};
  int exp6 [6]  = '{0, 1, 2, 0, 1, 2};

  initial begin
    serial = 1;
    for (int s = 0; s < 3; s++) begin head[s] = 0; tail[s] = 0; end
    sel_b = 0; n_src = 2; quant = 4;
    rst_i = 1; flush_i = 0; ready_i = 1;
    apply();
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    do_reset();

    // Both sources with 6 words: quantum of 4 alternates the owner.
    push(0, 6); push(1, 6);
    out_log.delete();
    run(14);
    check("seq1_len", 64'(out_log.size()), 64'd12);
    for (int i = 0; i < 12 && i < out_log.size(); i++) check("seq1", 64'(out_log[i]), 64'(exp1[i]));

    // Only src1 busy: no quantum break.
    push(1, 10);
    out_log.delete();
    run(13);
    check("seq2_len", 64'(out_log.size()), 64'd10);
    foreach (out_log[i]) check("seq2", 64'(out_log[i]), 64'd1);

    // Backpressure.
    do_reset();
    push(0, 3); push(1, 3);
    run(2);
    ready_i = 0; run(3);
    ready_i = 1; run(8);

    // Flush mid-burst on src0: resume on src1, nothing lost.
    do_reset();
    push(0, 6); push(1, 6);
    run(2);
    flush_i = 1; step(); flush_i = 0;
    step();
    check("flush_resume", 64'(last_rd), 64'h2);
    run(14);

    // Reset mid-burst: src0 granted first afterwards.
    do_reset();
    push(0, 5); push(1, 5);
    run(2);
    do_reset();
    step();
    push(0, 3); push(1, 3);
    step();
    check("reset_first", 64'(last_rd), 64'h1);
    run(8);

    random_phase(300);

    // Three sources, QUANTUM=1: strict rotation with pointer wrap.
    sel_b = 1; n_src = 3; quant = 1;
    model_reset();
    do_reset();
    push(0, 4); push(1, 4); push(2, 4);
    out_log.delete();
    run(8);
    check("seq6_len", 64'(out_log.size() >= 6), 64'd1);
    for (int i = 0; i < 6 && i < out_log.size(); i++) check("seq6", 64'(out_log[i]), 64'(exp6[i]));
    run(8);

    random_phase(300);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
